// File: rtl/pd_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Entries carry rd at RA_MAX_W bits; narrower register addresses are zero-extended.
package pd_hazard_pkg;

  localparam int unsigned RA_MAX_W  = 8;
  localparam int unsigned MAX_DEPTH = 16;
  localparam int unsigned FWD_RF    = 0;

  typedef struct packed {
    logic                valid;
    logic [RA_MAX_W-1:0] rd;
    logic                wen;
    logic                is_load;
  } trk_entry_t;

  localparam int unsigned ENTRY_W = $bits(trk_entry_t);

  // Forward select of the youngest (lowest-index) hit: index+1, or FWD_RF when nothing hits.
  function automatic int unsigned youngest_sel(input logic [MAX_DEPTH-1:0] hits);
    int unsigned sel;
    sel = FWD_RF;
    for (int i = int'(MAX_DEPTH) - 1; i >= 0; i--) begin
      if (hits[i]) sel = unsigned'(i) + 32'd1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_tracker.sv
// In-flight destination tracker for the X..W stages: a DEPTH-entry shift register.
// Entry 0 is the instruction currently in X; the oldest entry drops off each cycle.
module hazard_tracker
  import pd_hazard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned RA_W  = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ins_valid,
  input  logic [RA_W-1:0]            ins_rd,
  input  logic                       ins_wen,
  input  logic                       ins_is_load,
  output logic [DEPTH*ENTRY_W-1:0]   entries
);

  trk_entry_t ent_q [DEPTH];
  trk_entry_t ins_entry;

  always_comb begin
    ins_entry         = '0;
    ins_entry.valid   = ins_valid;
    ins_entry.rd      = RA_MAX_W'(ins_rd);
    ins_entry.wen     = ins_wen;
    ins_entry.is_load = ins_is_load;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
    end else begin
      ent_q[0] <= ins_entry;
      for (int i = 1; i < int'(DEPTH); i++) ent_q[i] <= ent_q[i-1];
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_flat
    assign entries[g*ENTRY_W +: ENTRY_W] = ent_q[g];
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline: forward selects, load-use
// stalls and taken-branch flushes. Optional perf counters under PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pd_hazard_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SEL_W    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [RA_W-1:0]  d_rs1,
  input  logic [RA_W-1:0]  d_rs2,
  input  logic             d_use_rs1,
  input  logic             d_use_rs2,
  input  logic [RA_W-1:0]  d_rd,
  input  logic             d_reg_wen,
  input  logic             d_is_load,
  input  logic             x_br_taken,
  output logic [SEL_W-1:0] fwd_sel_rs1,
  output logic [SEL_W-1:0] fwd_sel_rs2,
  output logic             stall_fd,
  output logic             bubble_x,
  output logic             flush_fd
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  logic [DEPTH*ENTRY_W-1:0] trk_flat;
  trk_entry_t               ent [DEPTH];
  logic [DEPTH-1:0]         hit_rs1, hit_rs2;
  logic                     ld_rs1, ld_rs2;
  logic                     load_use;
  int unsigned              sel_rs1, sel_rs2;

  hazard_tracker #(
    .DEPTH (DEPTH),
    .RA_W  (RA_W)
  ) u_tracker (
    .clock       (clock),
    .reset       (reset),
    .ins_valid   (d_valid & ~bubble_x),
    .ins_rd      (d_rd),
    .ins_wen     (d_reg_wen),
    .ins_is_load (d_is_load),
    .entries     (trk_flat)
  );

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_unpack
    assign ent[g] = trk_flat[g*ENTRY_W +: ENTRY_W];
  end

  // Scan oldest to youngest so the last hit seen decides the load flag.
  always_comb begin
    hit_rs1 = '0;
    hit_rs2 = '0;
    ld_rs1  = 1'b0;
    ld_rs2  = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      hit_rs1[i] = d_use_rs1 & ent[i].valid & ent[i].wen & (d_rs1 != '0) &
                   (ent[i].rd == RA_MAX_W'(d_rs1));
      hit_rs2[i] = d_use_rs2 & ent[i].valid & ent[i].wen & (d_rs2 != '0) &
                   (ent[i].rd == RA_MAX_W'(d_rs2));
      if (hit_rs1[i]) ld_rs1 = ent[i].is_load & (i < int'(LOAD_LAT));
      if (hit_rs2[i]) ld_rs2 = ent[i].is_load & (i < int'(LOAD_LAT));
    end
  end

  assign sel_rs1  = youngest_sel(MAX_DEPTH'(hit_rs1));
  assign sel_rs2  = youngest_sel(MAX_DEPTH'(hit_rs2));
  assign load_use = d_valid & (ld_rs1 | ld_rs2);

  // A taken branch kills D anyway, so it overrides any load-use stall.
  always_comb begin
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    stall_fd    = 1'b0;
    flush_fd    = 1'b0;
    bubble_x    = 1'b0;
    if (!reset) begin
      fwd_sel_rs1 = SEL_W'(sel_rs1);
      fwd_sel_rs2 = SEL_W'(sel_rs2);
      flush_fd    = x_br_taken;
      stall_fd    = load_use & ~x_br_taken;
      bubble_x    = x_br_taken | load_use;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_fd && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_fd && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_LAT 1 and 2) on shared stimulus,
// directed scenarios plus random traffic against an instruction-history model.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       d_valid, d_use_rs1, d_use_rs2, d_reg_wen, d_is_load, x_br_taken;
  logic [4:0] d_rs1, d_rs2, d_rd;

  logic [1:0] a_sel1, a_sel2, b_sel1, b_sel2;
  logic       a_stall, a_bub, a_flush, b_stall, b_bub, b_flush;
  logic [6:0] obs_a, obs_b;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  assign obs_a = {a_sel1, a_sel2, a_stall, a_bub, a_flush};
  assign obs_b = {b_sel1, b_sel2, b_stall, b_bub, b_flush};

  pipe_hazard_ctrl #(.DEPTH(3), .RA_W(5), .LOAD_LAT(1), .SEL_W(2)) u_dut_a (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd), .d_reg_wen(d_reg_wen),
    .d_is_load(d_is_load), .x_br_taken(x_br_taken), .fwd_sel_rs1(a_sel1),
    .fwd_sel_rs2(a_sel2), .stall_fd(a_stall), .bubble_x(a_bub), .flush_fd(a_flush)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
`endif
  );

  pipe_hazard_ctrl #(.DEPTH(3), .RA_W(5), .LOAD_LAT(2), .SEL_W(2)) u_dut_b (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd), .d_reg_wen(d_reg_wen),
    .d_is_load(d_is_load), .x_br_taken(x_br_taken), .fwd_sel_rs1(b_sel1),
    .fwd_sel_rs2(b_sel2), .stall_fd(b_stall), .bubble_x(b_bub), .flush_fd(b_flush)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
`endif
  );

  // Model: what entered X on each of the last three cycles, index 0 most recent.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       w;
    logic       l;
  } ent_t;
  typedef ent_t [2:0] hist_t;

  function automatic int producer(input hist_t h, input logic [4:0] rs, input logic used);
    if (!used || rs == 5'd0) return 0;
    for (int k = 0; k < 3; k++) begin
      if (h[k].v && h[k].w && h[k].rd == rs) return k + 1;
    end
    return 0;
  endfunction

  // Expected {sel1, sel2, stall, bubble, flush} for the current inputs.
  function automatic logic [6:0] model_out(input hist_t h, input int lat);
    int   s1, s2;
    logic lu, st;
    if (reset) return 7'd0;
    s1 = producer(h, d_rs1, d_use_rs1);
    s2 = producer(h, d_rs2, d_use_rs2);
    lu = 1'b0;
    if (s1 != 0 && (s1 - 1) < lat && h[s1-1].l) lu = 1'b1;
    if (s2 != 0 && (s2 - 1) < lat && h[s2-1].l) lu = 1'b1;
    st = d_valid && lu && !x_br_taken;
    return {2'(s1), 2'(s2), st, st | x_br_taken, x_br_taken};
  endfunction

  function automatic ent_t mk_ent(input logic bub);
    ent_t e;
    e.v  = d_valid & ~bub;
    e.rd = d_rd;
    e.w  = d_reg_wen;
    e.l  = d_is_load;
    return e;
  endfunction

  task automatic set_d(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic w, input logic l);
    d_valid = v; d_rs1 = r1; d_use_rs1 = u1; d_rs2 = r2; d_use_rs2 = u2;
    d_rd = rd; d_reg_wen = w; d_is_load = l;
  endtask

  task automatic nop();
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    x_br_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_d(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
    x_br_taken = 1'b1;
    #1;
    n_total++;
    if ({obs_a, obs_b} !== 14'd0) $display("FAIL reset_outputs: got %b/%b want 0", obs_a, obs_b);
    else n_pass++;
    reset = 1'b0;
    nop();
    tick();
    set_d(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    n_total++;
    if ({obs_a, obs_b} !== 14'd0) $display("FAIL reset_empty_tracker: got %b/%b want 0", obs_a, obs_b);
    else n_pass++;
  endtask

  task automatic test_alu_chain();
    logic [6:0] exp_v [4];
    exp_v[0] = 7'b01_00_000;
    exp_v[1] = 7'b10_00_000;
    exp_v[2] = 7'b11_00_000;
    exp_v[3] = 7'b00_00_000;
    drain();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_total++;
      if (obs_a !== exp_v[c] || obs_b !== exp_v[c])
        $display("FAIL alu_chain[%0d]: got %b/%b want %b", c, obs_a, obs_b, exp_v[c]);
      else n_pass++;
      tick();
      set_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_load_use();
    logic [6:0] ea [4];
    logic [6:0] eb [4];
    ea[0] = 7'b00_01_110; eb[0] = 7'b00_01_110;
    ea[1] = 7'b00_10_000; eb[1] = 7'b00_10_110;
    ea[2] = 7'b00_11_000; eb[2] = 7'b00_11_000;
    ea[3] = 7'b00_00_000; eb[3] = 7'b00_00_000;
    drain();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_total++;
      if (obs_a !== ea[c]) $display("FAIL load_use_lat1[%0d]: got %b want %b", c, obs_a, ea[c]);
      else n_pass++;
      n_total++;
      if (obs_b !== eb[c]) $display("FAIL load_use_lat2[%0d]: got %b want %b", c, obs_b, eb[c]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_shadow();
    drain();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    #1;
    n_total++;
    if ({obs_a, obs_b} !== 14'd0) $display("FAIL shadow_producer: got %b/%b want 0", obs_a, obs_b);
    else n_pass++;
    tick();
    set_d(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    #1;
    n_total++;
    if (obs_a !== 7'b01_00_000 || obs_b !== 7'b01_00_000)
      $display("FAIL shadow_consumer: got %b/%b want 0100000", obs_a, obs_b);
    else n_pass++;
  endtask

  task automatic test_x0_unused();
    drain();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    n_total++;
    if ({obs_a, obs_b} !== 14'd0) $display("FAIL x0_source: got %b/%b want 0", obs_a, obs_b);
    else n_pass++;
    tick();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    set_d(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    n_total++;
    if (obs_a !== 7'b01_00_000) $display("FAIL unused_rs2: got %b want 0100000", obs_a);
    else n_pass++;
    drain();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    set_d(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    n_total++;
    if (obs_a !== 7'b01_00_000 || obs_b !== 7'b01_00_000)
      $display("FAIL invalid_d_no_stall: got %b/%b want 0100000", obs_a, obs_b);
    else n_pass++;
    drain();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    tick();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    set_d(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    n_total++;
    if (obs_a !== 7'b01_10_000) $display("FAIL both_sources: got %b want 0110000", obs_a);
    else n_pass++;
  endtask

  task automatic test_flush();
    drain();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    x_br_taken = 1'b1;
    #1;
    n_total++;
    if (obs_a !== 7'b00_01_011 || obs_b !== 7'b00_01_011)
      $display("FAIL flush_priority: got %b/%b want 0001011", obs_a, obs_b);
    else n_pass++;
    tick();
    x_br_taken = 1'b0;
    set_d(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    n_total++;
    if ({obs_a, obs_b} !== 14'd0) $display("FAIL flush_killed_entry: got %b/%b want 0", obs_a, obs_b);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    n_total++;
    if (obs_a !== 7'b00_01_110) $display("FAIL pre_reset_stall: got %b want 0001110", obs_a);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++;
    if ({obs_a, obs_b} !== 14'd0) $display("FAIL reset_mid_stall: got %b/%b want 0", obs_a, obs_b);
    else n_pass++;
`ifdef PIPE_HAZARD_PERF_EN
    n_total++;
    if (a_scnt !== 32'd0 || b_scnt !== 32'd0)
      $display("FAIL reset_stall_cnt: got %0d/%0d want 0", a_scnt, b_scnt);
    else n_pass++;
`endif
    reset = 1'b0;
    #1;
    n_total++;
    if ({obs_a, obs_b} !== 14'd0) $display("FAIL after_reset_release: got %b/%b want 0", obs_a, obs_b);
    else n_pass++;
  endtask

`ifdef PIPE_HAZARD_PERF_EN
  task automatic test_perf();
    nop();
    reset = 1'b1;
    #1 reset = 1'b0;
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    repeat (3) tick();
    nop();
    x_br_taken = 1'b1;
    tick();
    x_br_taken = 1'b0;
    #1;
    n_total++;
    if (a_scnt !== 32'd1 || a_fcnt !== 32'd1)
      $display("FAIL perf_lat1: got %0d/%0d want 1/1", a_scnt, a_fcnt);
    else n_pass++;
    n_total++;
    if (b_scnt !== 32'd2 || b_fcnt !== 32'd1)
      $display("FAIL perf_lat2: got %0d/%0d want 2/1", b_scnt, b_fcnt);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    hist_t      h1, h2;
    logic [6:0] ea, eb;
    nop();
    reset = 1'b1;
    #1 reset = 1'b0;
    h1 = '0;
    h2 = '0;
    repeat (400) begin
      set_d($urandom_range(9) != 0, 5'($urandom_range(7)), 1'($urandom),
            5'($urandom_range(7)), 1'($urandom), 5'($urandom_range(7)), 1'($urandom),
            $urandom_range(2) == 0);
      x_br_taken = ($urandom_range(7) == 0);
      #1;
      ea = model_out(h1, 1);
      eb = model_out(h2, 2);
      n_total++;
      if (obs_a !== ea) $display("FAIL random_lat1: got %b want %b", obs_a, ea);
      else n_pass++;
      n_total++;
      if (obs_b !== eb) $display("FAIL random_lat2: got %b want %b", obs_b, eb);
      else n_pass++;
      @(posedge clock);
      h1 = {h1[1:0], mk_ent(ea[1])};
      h2 = {h2[1:0], mk_ent(eb[1])};
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    nop();
    reset = 1'b0;
    #2;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_shadow();
    test_x0_unused();
    test_flush();
    test_reset_mid_stall();
`ifdef PIPE_HAZARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
